// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared state encoding and default width for the sequential divider
package div_seq_pkg;
    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;
endpackage

// File: rtl/div_seq_sub_stage.sv
// rtl/div_seq_sub_stage.sv - combinational W-bit subtractor a + ~b + 1 with split sign bit
module sub_stage #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-2:0] diff,
    output logic         sign
);
    logic [W-1:0] full;

    assign full = a + ~b + {{(W-1){1'b0}}, 1'b1};
    assign diff = full[W-2:0];
    assign sign = full[W-1];
endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - restoring unsigned divider, one quotient bit per clock, MSB first
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sub_diff;
    logic             sub_sign;

    // dvd_q doubles as the working dividend and the quotient being shifted in
    sub_stage #(.W(WIDTH + 1)) u_sub (
        .a    ({rem_q, dvd_q[WIDTH-1]}),
        .b    ({1'b0, dvs_q}),
        .diff (sub_diff),
        .sign (sub_sign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                    rem_d   = '0;
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    dbz_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_CALC: begin
                if (dvs_q == '0) begin
                    state_d = ST_DONE;
                    dvd_d   = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    rem_d = sub_sign ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : sub_diff;
                    dvd_d = {dvd_q[WIDTH-2:0], ~sub_sign};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = dvd_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - randomized and directed self-checking bench for div_seq
module tb_div_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tcyc = 0;
    int done_at[$];

    // reference: a countdown timer plus the arithmetic answer fixed at acceptance
    logic         m_busy, m_done, m_dbz, m_rv;
    logic [W-1:0] m_q, m_r, p_q, p_r;
    logic         p_dbz;
    int           m_left;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, tcyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_left = 0; m_rv = 1;
        m_q = '0; m_r = '0; m_dbz = 0;
    endtask

    task automatic model_step(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (!rst_n) begin
            model_reset();
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_rv = 1;
                m_q = p_q; m_r = p_r; m_dbz = p_dbz;
            end
        end else if (s) begin
            m_busy = 1; m_rv = 0;
            m_left = (b == 0) ? 1 : W;
            p_q    = (b == 0) ? {W{1'b1}} : a / b;
            p_r    = (b == 0) ? a : a % b;
            p_dbz  = (b == 0);
        end
    endtask

    task automatic compare();
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        if (m_rv) begin
            chk("quotient", 64'(quotient), 64'(m_q));
            chk("remainder", 64'(remainder), 64'(m_r));
            chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        end
    endtask

    // entered and left at a negedge: drive, step model at posedge, compare at negedge
    task automatic cyc(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        start = s; dividend = a; divisor = b;
        @(posedge clk);
        model_step(s, a, b);
        tcyc++;
        @(negedge clk);
        if (done === 1'b1) done_at.push_back(tcyc);
        compare();
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        cyc(1'b1, a, b);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            cyc(1'b0, '0, '0);
            lat++;
        end
        if (lat >= 200) chk("done_timeout", 64'(lat), 64'(0));
        cyc(1'b0, '0, '0);
    endtask

    task automatic lit(input string nm, input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        chk({nm, "_q"}, 64'(quotient), 64'(q));
        chk({nm, "_r"}, 64'(remainder), 64'(r));
        chk({nm, "_dbz"}, 64'(div_by_zero), 64'(z));
    endtask

    function automatic logic [W-1:0] rnd_op(input int kind);
        case (kind)
            0: rnd_op = '0;
            1: rnd_op = W'($urandom_range(1, 15));
            2: rnd_op = {1'b1, W'($urandom) >> 1};
            3: rnd_op = W'($urandom) >> $urandom_range(0, W - 1);
            default: rnd_op = W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int ndone;
        int guard;
        model_reset();
        @(negedge clk);
        compare();
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_q", 64'(quotient), 64'(0));
        cyc(1'b0, '0, '0);
        rst_n = 1'b1;

        run_div(32'd100, 32'd7, lat);
        chk("lat_100_7", 64'(lat), 64'(W));
        lit("d100_7", 32'd14, 32'd2, 1'b0);
        run_div(32'hFFFFFFFF, 32'h80000001, lat);
        lit("dmax_big", 32'd1, 32'h7FFFFFFE, 1'b0);
        run_div(32'hFFFFFFFF, 32'd1, lat);
        lit("dmax_1", 32'hFFFFFFFF, 32'd0, 1'b0);
        run_div(32'd3, 32'd10, lat);
        lit("d3_10", 32'd0, 32'd3, 1'b0);
        run_div(32'd5, 32'd0, lat);
        chk("lat_div0", 64'(lat), 64'(1));
        lit("d5_0", 32'hFFFFFFFF, 32'd5, 1'b1);

        // second start while busy must be ignored
        cyc(1'b1, 32'd1000, 32'd3);
        for (int i = 1; i <= 4; i++) cyc(1'b0, '0, '0);
        cyc(1'b1, 32'd8, 32'd2);
        guard = 0;
        while (done !== 1'b1 && guard < 100) begin cyc(1'b0, '0, '0); guard++; end
        lit("ignored_start", 32'd333, 32'd1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0);

        // reset in the middle of a division
        cyc(1'b1, 32'd12345, 32'd7);
        for (int i = 1; i <= 9; i++) cyc(1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_r", 64'(remainder), 64'(0));
        @(negedge clk);
        cyc(1'b0, '0, '0);
        rst_n = 1'b1;
        done_at.delete();
        for (int i = 0; i < 40; i++) cyc(1'b0, '0, '0);
        chk("no_stray_done", 64'(done_at.size()), 64'(0));
        run_div(32'd9, 32'd4, lat);
        lit("d9_4", 32'd2, 32'd1, 1'b0);

        // start held high: back-to-back divisions
        done_at.delete();
        guard = 0;
        while (done_at.size() < 3 && guard < 500) begin
            cyc(1'b1, W'($urandom), W'($urandom_range(1, 1000)));
            guard++;
        end
        chk("b2b_count", 64'(done_at.size()), 64'(3));
        if (done_at.size() == 3) begin
            chk("b2b_gap1", 64'(done_at[1] - done_at[0]), 64'(W + 2));
            chk("b2b_gap2", 64'(done_at[2] - done_at[1]), 64'(W + 2));
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0);

        // randomized traffic, including starts while busy
        for (int n = 0; n < 2500; n++) begin
            logic s;
            s = ($urandom_range(0, 2) == 0);
            cyc(s, rnd_op($urandom_range(1, 5)), rnd_op($urandom_range(0, 6)));
        end
        ndone = 0;
        while (m_busy && ndone < 100) begin cyc(1'b0, '0, '0); ndone++; end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; legal range 4..32.
REQ-002 Port: clk  input  1  rising-edge clock, the only clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a division, sampled on rising clk edges.
REQ-005 Port: dividend  input  WIDTH  unsigned dividend, sampled with start.
REQ-006 Port: divisor  input  WIDTH  unsigned divisor, sampled with start.
REQ-007 Port: busy  output  1  high while a division is in progress, including the DONE cycle.
REQ-008 Port: done  output  1  one-cycle pulse; results are valid from this cycle onward.
REQ-009 Port: quotient  output  WIDTH  unsigned quotient.
REQ-010 Port: remainder  output  WIDTH  unsigned remainder.
REQ-011 Port: div_by_zero  output  1  set with done when the latched divisor was 0.

Function
REQ-012 The block SHALL implement restoring division on unsigned operands: quotient = dividend / divisor and remainder = dividend mod divisor.
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 In IDLE, start=1 at edge k SHALL latch both operands, clear the iteration counter and move to CALC; busy SHALL be high from edge k onward.
REQ-015 Each CALC cycle SHALL perform one iteration, MSB first:
- shift {partial remainder, working dividend} left by 1;
- subtract the divisor from the (WIDTH+1)-bit partial remainder;
- if the difference is non-negative, keep it and set quotient bit 1;
- otherwise restore the partial remainder and set quotient bit 0.
REQ-016 CALC SHALL last exactly WIDTH cycles; the transition to DONE SHALL occur at edge k+WIDTH.
REQ-017 done SHALL be high only in the cycle after edge k+WIDTH; the FSM SHALL return to IDLE at edge k+WIDTH+1, which SHALL also deassert busy.
REQ-018 When the divisor is 0 at edge k, the block SHALL go directly to DONE at edge k+1, with quotient = all ones, remainder = dividend and div_by_zero = 1.
REQ-019 On a non-zero divisor, div_by_zero SHALL be 0 in the DONE cycle.
REQ-020 While busy is high, start SHALL be ignored and the latched operands SHALL not change.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values after done until the next accepted start; they are undefined during CALC.
REQ-022 start held high continuously SHALL produce back-to-back divisions, with one IDLE cycle between done and the next acceptance.
REQ-023 The subtract SHALL be WIDTH+1 bits wide, so a dividend with its MSB set and a divisor greater than 2^(WIDTH-1) produce correct results.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and clear the counter, without waiting for clk.
REQ-025 A reset during CALC or DONE SHALL abort the division; no done pulse SHALL follow the release of reset.
REQ-026 After reset release, the first start SHALL be accepted on the first rising edge at which rst_n is high.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-028 The (WIDTH+1)-bit subtractor SHALL be a separate combinational sub-module, sub_stage, computing A + ~B + 1 and exposing the difference and its sign bit; div_seq SHALL instantiate it once.
REQ-029 All state registers SHALL be in a single always block clocked by clk with asynchronous reset on rst_n.

Verification
REQ-030 100 / 7, start pulsed at edge k -> done in the cycle after edge k+32, quotient=14, remainder=2, div_by_zero=0.
REQ-031 32'hFFFFFFFF / 32'h80000001 -> quotient=1, remainder=32'h7FFFFFFE; 32'hFFFFFFFF / 1 -> quotient=32'hFFFFFFFF, remainder=0.
REQ-032 3 / 10 -> quotient=0, remainder=3; 5 / 0 -> done in the cycle after edge k+1, quotient=32'hFFFFFFFF, remainder=5, div_by_zero=1.
REQ-033 Start 1000 / 3, then pulse start with 8 / 2 at edge k+5 -> the second request is ignored; results are quotient=333, remainder=1.
REQ-034 Assert rst_n=0 at edge k+10 of a division, release it, then start 9 / 4 -> no stray done pulse; outputs read 0 during reset; results are quotient=2, remainder=1.
REQ-035 start held high for 3 divisions -> exactly 3 done pulses, each separated by WIDTH+2 cycles.
